// File: rtl/rr_arbiter4_if.sv
// Signal bundle between the four clients and the round-robin arbiter.
// slave = arbiter side, master = client side.
interface rr_arbiter4_if #(
    parameter int MAX_HOLD = 8
) ();
    localparam int HCW = $clog2(MAX_HOLD + 1);

    // Handshake: req is a level held by each client for as long as it wants the
    // resource; the registered one-hot gnt acts as the ready for that client, and
    // the client owns the resource in exactly those cycles where its gnt bit is 1.
    logic [3:0]     req;
    logic [3:0]     gnt;
    logic [1:0]     gnt_idx;
    logic           gnt_valid;
    logic           preempt;
    logic           busy_dbg;
    logic [1:0]     ptr_dbg;
    logic [HCW-1:0] hold_cnt_dbg;

    modport slave (
        input  req,
        output gnt, gnt_idx, gnt_valid, preempt,
        output busy_dbg, ptr_dbg, hold_cnt_dbg
    );

    modport master (
        output req,
        input  gnt, gnt_idx, gnt_valid, preempt,
        input  busy_dbg, ptr_dbg, hold_cnt_dbg
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant and a bounded
// hold time under contention (forced rotation after MAX_HOLD cycles).
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter4_if.slave  bus
);
    localparam int HCW = $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_ONE = HCW'(1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [1:0]     gnt_idx_q, gnt_idx_d;
    logic           gnt_valid_q, gnt_valid_d;
    logic           preempt_q, preempt_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]     gnt_q, gnt_d;

    logic [3:0]     req;
    logic [1:0]     g_next;
    logic [3:0]     others;

    // First set bit of v scanning start, start+1, ... mod 4; callers guarantee v != 0.
    function automatic logic [1:0] pick(input logic [1:0] start, input logic [3:0] v);
        logic [1:0] r;
        logic [1:0] idx;
        r = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (v[idx]) r = idx;
        end
        return r;
    endfunction

    assign req    = bus.req;
    assign g_next = gnt_idx_q + 2'd1;
    assign others = req & ~(4'b0001 << gnt_idx_q);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        hold_cnt_d  = hold_cnt_q;
        preempt_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_idx_d   = pick(ptr_q, req);
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = HOLD_ONE;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                // Release wins over the hold limit, so a release never pulses preempt.
                if (!req[gnt_idx_q]) begin
                    ptr_d = g_next;
                    if (|req) begin
                        gnt_idx_d  = pick(g_next, req);
                        hold_cnt_d = HOLD_ONE;
                    end else begin
                        gnt_valid_d = 1'b0;
                        hold_cnt_d  = '0;
                        state_d     = IDLE;
                    end
                end else if (hold_cnt_q == HOLD_MAX && |others) begin
                    gnt_idx_d  = pick(g_next, others);
                    hold_cnt_d = HOLD_ONE;
                    ptr_d      = g_next;
                    preempt_d  = 1'b1;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_d = gnt_valid_d ? (4'b0001 << gnt_idx_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            gnt_idx_q   <= 2'd0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            hold_cnt_q  <= '0;
            gnt_q       <= 4'b0000;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.gnt_idx      = gnt_idx_q;
    assign bus.gnt_valid    = gnt_valid_q;
    assign bus.preempt      = preempt_q;
    assign bus.busy_dbg     = (state_q == BUSY);
    assign bus.ptr_dbg      = ptr_q;
    assign bus.hold_cnt_dbg = hold_cnt_q;
endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed-vector bench for rr_arbiter4 (MAX_HOLD=4): the driver pushes the
// hand-computed post-edge outputs, a monitor pops and compares every cycle.
module tb_rr_arbiter4;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_arbiter4_if #(.MAX_HOLD(MH)) bus ();

    rr_arbiter4 #(.MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected entry: {gnt[3:0], gnt_idx[1:0], gnt_valid, preempt}
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg, input logic ep);
        @(negedge clk);
        rst     = r;
        bus.req = rq;
        exp_q.push_back({eg, oh2idx(eg), |eg, ep});
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got %0d expected %0d", name, got, exp);
    endtask

    // Monitor: compares the outputs after every rising edge against the queue.
    initial begin
        logic [7:0] e;
        logic       idx_ok;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                idx_ok = !e[1] || (bus.gnt_idx == e[3:2]);
                n_checks++;
                if (bus.gnt == e[7:4] && idx_ok && bus.gnt_valid == e[1] && bus.preempt == e[0])
                    n_pass++;
                else
                    $display("FAIL cycle%0d gnt/idx/valid/preempt got %b/%0d/%b/%b expected %b/%0d/%b/%b",
                             cyc, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.preempt,
                             e[7:4], e[3:2], e[1], e[0]);
            end
        end
    end

    initial begin
        bus.req = 4'b0000;

        // Reset held with all requests, then first grant goes to 0.
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 4'b0000, 1'b0);
        step(1'b0, 4'b1111, 4'b0001, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);   // release -> idle, ptr=1

        // Single request from idle, held, then dropped.
        step(1'b0, 4'b0100, 4'b0100, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 4'b0100, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        @(posedge clk);
        #2;
        chk("ptr_after_release", int'(bus.ptr_dbg), 3);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);

        // Round robin from ptr=3: each grantee drops its bit after 2 grant cycles.
        step(1'b0, 4'b1111, 4'b1000, 1'b0);
        step(1'b0, 4'b1111, 4'b1000, 1'b0);
        step(1'b0, 4'b0111, 4'b0001, 1'b0);
        step(1'b0, 4'b1111, 4'b0001, 1'b0);
        step(1'b0, 4'b1110, 4'b0010, 1'b0);
        step(1'b0, 4'b1111, 4'b0010, 1'b0);
        step(1'b0, 4'b1101, 4'b0100, 1'b0);
        step(1'b0, 4'b1111, 4'b0100, 1'b0);
        step(1'b0, 4'b1011, 4'b1000, 1'b0);
        step(1'b0, 4'b1111, 4'b1000, 1'b0);
        step(1'b0, 4'b0111, 4'b0001, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);

        // Forced rotation between 0 and 1, starting from a fresh reset.
        step(1'b1, 4'b0011, 4'b0000, 1'b0);
        step(1'b0, 4'b0011, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0011, 4'b0001, 1'b0);
        step(1'b0, 4'b0011, 4'b0010, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0011, 4'b0010, 1'b0);
        step(1'b0, 4'b0011, 4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0011, 4'b0001, 1'b0);
        // Release coinciding with the hold limit: no preempt.
        step(1'b0, 4'b0010, 4'b0010, 1'b0);
        step(1'b0, 4'b0010, 4'b0010, 1'b0);
        // Three-way contention: rotation skips the holder and wraps 3 -> 0.
        step(1'b0, 4'b1011, 4'b0010, 1'b0);
        step(1'b0, 4'b1011, 4'b0010, 1'b0);
        step(1'b0, 4'b1011, 4'b1000, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1011, 4'b1000, 1'b0);
        step(1'b0, 4'b1011, 4'b0001, 1'b1);

        // Lone holder keeps the grant for 20 cycles; counter saturates.
        for (int i = 0; i < 20; i++) step(1'b0, 4'b1000, 4'b1000, 1'b0);
        @(posedge clk);
        #2;
        chk("hold_cnt_saturated", int'(bus.hold_cnt_dbg), MH);

        // Reset in the middle of a grant to requester 1.
        step(1'b0, 4'b0111, 4'b0001, 1'b0);
        step(1'b0, 4'b1110, 4'b0010, 1'b0);
        step(1'b0, 4'b1111, 4'b0010, 1'b0);
        step(1'b1, 4'b1111, 4'b0000, 1'b0);
        step(1'b0, 4'b1111, 4'b0001, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
